// File: rtl/trap_report_arbiter.sv
// trap_report_arbiter
// Collects one-shot trap reports from NUM_HARTS harts and serialises them onto a single
// valid/ready monitor port. Each hart has a one-deep holding slot. A round-robin arbiter
// moves pending slots into a registered output stage. End-of-simulation status is also kept.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   in_valid[i]           one-cycle report strobe from hart i
//   in_code/pc/cycle/instr  32-bit fields per hart, hart i at [32i+31:32i]
//   out_valid/out_ready   output handshake; out_* fields are held while stalled
//   out_hart, out_code, out_pc, out_cycle, out_instr   held report
//   reported              sticky per-hart "delivered at least once"
//   all_done              every hart reported, no slot pending, output empty
//   first_bad_valid/code/hart  first delivered report with a nonzero code
//   overflow              sticky: a report arrived while its slot was still occupied
//   deliv_cnt             delivered-report count, saturating
module trap_report_arbiter #(
  parameter int unsigned NUM_HARTS = 2,
  localparam int unsigned HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_HARTS-1:0]      in_valid,
  input  logic [32*NUM_HARTS-1:0]   in_code,
  input  logic [32*NUM_HARTS-1:0]   in_pc,
  input  logic [32*NUM_HARTS-1:0]   in_cycle,
  input  logic [32*NUM_HARTS-1:0]   in_instr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [HW-1:0]             out_hart,
  output logic [31:0]               out_code,
  output logic [31:0]               out_pc,
  output logic [31:0]               out_cycle,
  output logic [31:0]               out_instr,
  output logic [NUM_HARTS-1:0]      reported,
  output logic                      all_done,
  output logic                      first_bad_valid,
  output logic [31:0]               first_bad_code,
  output logic [HW-1:0]             first_bad_hart,
  output logic                      overflow,
  output logic [15:0]               deliv_cnt
);

  // Slot payload packing: {instr, cycle, pc, code}.
  logic [NUM_HARTS-1:0] pending;
  logic [127:0]         slotData [NUM_HARTS];
  logic [HW-1:0]        rrPtr;

  logic                 fire;
  logic                 canGrant;
  logic                 grantFound;
  logic [HW-1:0]        grantIdx;
  logic [HW-1:0]        rrNext;
  logic [NUM_HARTS-1:0] freed;

  assign fire     = out_valid && out_ready;
  assign canGrant = !out_valid || out_ready;

  // First pending slot at or after rrPtr, wrapping.
  always_comb begin
    int unsigned cand;
    cand       = 0;
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int unsigned k = 0; k < NUM_HARTS; k++) begin
      cand = int'(rrPtr) + k;
      if (cand >= NUM_HARTS) cand = cand - NUM_HARTS;
      if (!grantFound && pending[cand[HW-1:0]]) begin
        grantFound = 1'b1;
        grantIdx   = cand[HW-1:0];
      end
    end
  end

  always_comb begin
    rrNext = (grantIdx == HW'(NUM_HARTS - 1)) ? '0 : grantIdx + HW'(1);
    freed  = '0;
    if (canGrant && grantFound) freed[grantIdx] = 1'b1;
  end

  // Holding slots. A slot granted this cycle may be refilled at the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < NUM_HARTS; i++) slotData[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_HARTS; i++) begin
        if (in_valid[i] && (!pending[i] || freed[i])) begin
          pending[i]  <= 1'b1;
          slotData[i] <= {in_instr[32*i +: 32], in_cycle[32*i +: 32],
                          in_pc[32*i +: 32], in_code[32*i +: 32]};
        end else if (freed[i]) begin
          pending[i] <= 1'b0;
        end
      end
      if (|(in_valid & pending & ~freed)) overflow <= 1'b1;
    end
  end

  // Registered output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_hart  <= '0;
      out_code  <= '0;
      out_pc    <= '0;
      out_cycle <= '0;
      out_instr <= '0;
      rrPtr     <= '0;
    end else if (canGrant) begin
      if (grantFound) begin
        out_valid <= 1'b1;
        out_hart  <= grantIdx;
        out_code  <= slotData[grantIdx][31:0];
        out_pc    <= slotData[grantIdx][63:32];
        out_cycle <= slotData[grantIdx][95:64];
        out_instr <= slotData[grantIdx][127:96];
        rrPtr     <= rrNext;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Delivery status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reported        <= '0;
      deliv_cnt       <= '0;
      first_bad_valid <= 1'b0;
      first_bad_code  <= '0;
      first_bad_hart  <= '0;
    end else if (fire) begin
      reported[out_hart] <= 1'b1;
      if (deliv_cnt != 16'hFFFF) deliv_cnt <= deliv_cnt + 16'd1;
      if (out_code != 32'd0 && !first_bad_valid) begin
        first_bad_valid <= 1'b1;
        first_bad_code  <= out_code;
        first_bad_hart  <= out_hart;
      end
    end
  end

  assign all_done = (&reported) && !(|pending) && !out_valid;

endmodule
